fw_cmd_decoder: RTL
===================

# fw_cmd_decoder

Command front-end for the CMS pix28 test firmware. It sits between the software-facing 32-bit write/read registers and the IP test engines. It decodes each host word into device_id, op_code and body, and holds the static configuration and execute registers. It forwards configuration-array and data-array traffic to the array stage, and keeps the 32-bit sticky status word.

## Interface
Parameters:
- `FW_ID`, default 4'h1 (`firmware_id_1`): device_id this instance answers to.
- `TEST_NUMBER_LSB`, default 14: LSB of the 4-bit test_number field in the execute body.
  - 14 for IP1; 12 for IP2.
- `RD_TIMEOUT`, default 255: clocks to wait for `arr_rd_ack`; 8-bit counter.

Ports:
- `fw_axi_clk`  in  1  — single clock.
- `fw_rst_n`  in  1  — asynchronous active-low reset.
- `sw_write32`  in  32  — command word.
  - [31:28] device_id, [27:24] op_code, [23:0] body.
- `sw_write32_valid`  in  1  — one-cycle command strobe.
- `sw_read32`  out  32  — read response word.
- `sw_read32_valid`  out  1  — one-cycle response strobe.
- `cmd_busy`  out  1  — high while the FSM is not IDLE.
- `fw_rst_req`  out  1  — one-cycle soft-reset pulse to the IP.
- `cfg_static_0`  out  24  — static configuration register 0.
- `cfg_static_1`  out  24  — static configuration register 1.
- `exec_cfg`  out  24  — execute configuration register.
- `exec_start`  out  1  — one-cycle test start pulse.
- `test_done`  in  4  — one-hot completion pulse from the IP, bit k = test k+1.
- `arr_wr_valid`  out  1  — one-cycle array write strobe.
- `arr_sel`  out  3  — array select.
  - 0/1/2 = cfg array 0/1/2; 4/5 = data array 0/1.
- `arr_wr_data`  out  24  — array write chunk.
- `arr_rd_req`  out  1  — array read request, level.
- `arr_rd_ack`  in  1  — array read acknowledge.
- `arr_rd_data`  in  24  — array read data, valid with `arr_rd_ack`.
- `status`  out  32  — sticky status word.

## Operation
- FSM states: IDLE, DISPATCH, RD_WAIT.
- **Reset.** All outputs, registers, `exec_running` and `status` are 0; state is IDLE.
- **Command acceptance.**
  - In IDLE, a strobe with device_id == `FW_ID` latches the word and moves the FSM to DISPATCH.
  - A device_id mismatch is ignored silently.
  - A strobe while `cmd_busy` is dropped and sets status[18] (`error_cmd_dropped`).
- **DISPATCH** acts on op_code, then returns to IDLE unless noted:
  - NOOP: no action.
  - W_RST_FW: pulse `fw_rst_req`; clear `cfg_static_*`, `exec_cfg` and `exec_running`; status becomes only bit 0 set.
  - W_CFG_STATIC_0/1: load the body into the register; set status[1] or status[3].
  - R_CFG_STATIC_0/1: `sw_read32` = {FW_ID, op_code, register}; pulse `sw_read32_valid`; set status[2] or status[4].
  - W_CFG_ARRAY_n: pulse `arr_wr_valid` with `arr_sel`=n and the body; set the matching status bit (5/7/9).
  - R_CFG_ARRAY_n and R_DATA_ARRAY_n: raise `arr_rd_req` with `arr_sel`; go to RD_WAIT.
  - W_STATUS_FW_CLEAR: status becomes 0. `exec_running` is unaffected.
  - W_EXECUTE, rejected if the test_number field is not one-hot or `exec_running`=1:
    - set status[31] only;
    - `exec_cfg` is unchanged and there is no pulse.
  - W_EXECUTE, otherwise:
    - load `exec_cfg`, pulse `exec_start`;
    - set `exec_running` and status[13];
    - remember the test_number.
- **RD_WAIT.**
  - On `arr_rd_ack`: drop the request; `sw_read32` = {FW_ID, op_code, arr_rd_data}; pulse valid; set the status bit (6/8/10/11/12); go to IDLE.
  - After `RD_TIMEOUT` clocks without ack: drop the request; respond with body 24'hFFFFFF; set status[19] (`error_rd_timeout`); go to IDLE.
- **Test completion.** A `test_done` bit equal to the remembered test_number while `exec_running`:
  - sets status[14+k];
  - clears `exec_running`.
- A non-matching `test_done` bit is ignored.

## Timing
- Strobe sampled on edge E; the FSM is in DISPATCH after E.
- All DISPATCH effects (register loads, pulses, read response) are registered on edge E+1.
- Minimum command spacing is 2 clocks.
- Array read response: `sw_read32_valid` is registered on the edge after the ack is sampled.
- `arr_rd_req` is high from E+1 until that edge.
- A `test_done` pulse in the same cycle as a STATUS_CLEAR or W_RST_FW dispatch: the clear applies first, then the done bit is set.
- `test_done` is processed in any state.
- Reset asserted mid-RD_WAIT: `arr_rd_req` falls asynchronously; no response is issued.

## Structure
- `cms_pix28_package` receives:
  - `status_index_error_cmd_dropped` = 18;
  - `status_index_error_rd_timeout` = 19;
  - the FSM enum `state_t_sm_cmd_dec` {IDLE, DISPATCH, RD_WAIT};
  - arr_sel encodings.
- The op_code enum and status indices are reused from the package.
- No sub-module; a single module.

## Test plan
- Reset, then W_CFG_STATIC_0 body 0x00ABCD, then R_CFG_STATIC_0:
  - read word 0x1300ABCD;
  - status = 0x6.
- W_EXECUTE with test_number 4'b0011 → no `exec_start`; status[31]=1.
- W_EXECUTE with 4'b0010, then `test_done`=4'b0010:
  - `exec_start` pulse;
  - status bits 13 and 15 set;
  - `exec_running` cleared.
- R_DATA_ARRAY_1 with ack after 10 clocks carrying 0x5A5A5A:
  - `arr_sel`=5;
  - response 0x1D5A5A5A;
  - status[12] set.
- R_CFG_ARRAY_0 with no ack → response 0x17FFFFFF after 255 clocks; status[19] set.
- Second strobe one clock after the first → dropped; status[18] set.
- Word with device_id 4'h2 → no effect.

Source files
------------

// File: rtl/cms_pix28_package.sv
// Shared definitions for the pix28 test firmware: op codes, FSM states,
// status bit positions and array-select encodings.
package cms_pix28_package;

    typedef enum logic [3:0] {
        NOOP              = 4'h0,
        W_RST_FW          = 4'h1,
        W_CFG_STATIC_0    = 4'h2,
        R_CFG_STATIC_0    = 4'h3,
        W_CFG_STATIC_1    = 4'h4,
        R_CFG_STATIC_1    = 4'h5,
        W_CFG_ARRAY_0     = 4'h6,
        R_CFG_ARRAY_0     = 4'h7,
        W_CFG_ARRAY_1     = 4'h8,
        R_CFG_ARRAY_1     = 4'h9,
        W_CFG_ARRAY_2     = 4'hA,
        R_CFG_ARRAY_2     = 4'hB,
        R_DATA_ARRAY_0    = 4'hC,
        R_DATA_ARRAY_1    = 4'hD,
        W_STATUS_FW_CLEAR = 4'hE,
        W_EXECUTE         = 4'hF
    } op_code_t;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        RD_WAIT
    } state_t_sm_cmd_dec;

    localparam logic [4:0] status_index_rst_fw            = 5'd0;
    localparam logic [4:0] status_index_execute           = 5'd13;
    localparam logic [4:0] status_index_error_cmd_dropped = 5'd18;
    localparam logic [4:0] status_index_error_rd_timeout  = 5'd19;
    localparam logic [4:0] status_index_error_execute     = 5'd31;

    localparam logic [2:0] ARR_SEL_CFG_0  = 3'd0;
    localparam logic [2:0] ARR_SEL_CFG_1  = 3'd1;
    localparam logic [2:0] ARR_SEL_CFG_2  = 3'd2;
    localparam logic [2:0] ARR_SEL_DATA_0 = 3'd4;
    localparam logic [2:0] ARR_SEL_DATA_1 = 3'd5;

    function automatic logic [2:0] arr_sel_of(input op_code_t op);
        case (op)
            W_CFG_ARRAY_0, R_CFG_ARRAY_0: return ARR_SEL_CFG_0;
            W_CFG_ARRAY_1, R_CFG_ARRAY_1: return ARR_SEL_CFG_1;
            W_CFG_ARRAY_2, R_CFG_ARRAY_2: return ARR_SEL_CFG_2;
            R_DATA_ARRAY_0:               return ARR_SEL_DATA_0;
            R_DATA_ARRAY_1:               return ARR_SEL_DATA_1;
            default:                      return ARR_SEL_CFG_0;
        endcase
    endfunction

    // Completion bit of a register/array op sits one below its op code.
    function automatic logic [4:0] status_index_of(input op_code_t op);
        if (op == W_EXECUTE) return status_index_execute;
        return 5'(op) - 5'd1;
    endfunction

endpackage

// File: rtl/fw_cmd_decoder.sv
// Host command front-end: decodes 32-bit command words, holds static/execute
// configuration, forwards array traffic and keeps the sticky status word.
module fw_cmd_decoder
    import cms_pix28_package::*;
#(
    parameter logic [3:0]  FW_ID           = 4'h1,
    parameter int unsigned TEST_NUMBER_LSB = 14,
    parameter int unsigned RD_TIMEOUT      = 255
) (
    input  logic        fw_axi_clk,
    input  logic        fw_rst_n,
    input  logic [31:0] sw_write32,
    input  logic        sw_write32_valid,
    output logic [31:0] sw_read32,
    output logic        sw_read32_valid,
    output logic        cmd_busy,
    output logic        fw_rst_req,
    output logic [23:0] cfg_static_0,
    output logic [23:0] cfg_static_1,
    output logic [23:0] exec_cfg,
    output logic        exec_start,
    input  logic [3:0]  test_done,
    output logic        arr_wr_valid,
    output logic [2:0]  arr_sel,
    output logic [23:0] arr_wr_data,
    output logic        arr_rd_req,
    input  logic        arr_rd_ack,
    input  logic [23:0] arr_rd_data,
    output logic [31:0] status
);

    localparam logic [7:0] RD_LAST = 8'(RD_TIMEOUT - 1);

    state_t_sm_cmd_dec state_q, state_d;
    logic [27:0] cmd_q, cmd_d;
    logic [23:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d, exec_cfg_q, exec_cfg_d;
    logic        running_q, running_d;
    logic [3:0]  tnum_q, tnum_d;
    logic [31:0] status_q, status_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;
    logic [31:0] read_q, read_d;
    logic        rd_valid_q, rd_valid_d, rst_req_q, rst_req_d;
    logic        exec_start_q, exec_start_d, wr_valid_q, wr_valid_d;
    logic [2:0]  arr_sel_q, arr_sel_d;
    logic [23:0] wr_data_q, wr_data_d;
    logic        rd_req_q, rd_req_d;

    op_code_t    op;
    logic [23:0] body;
    logic [3:0]  tnum;
    logic [3:0]  done_hit;
    logic        status_clr;
    logic [31:0] status_set;

    assign op       = op_code_t'(cmd_q[27:24]);
    assign body     = cmd_q[23:0];
    assign tnum     = body[TEST_NUMBER_LSB +: 4];
    assign done_hit = test_done & tnum_q;

    always_ff @(posedge fw_axi_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            cfg0_q       <= '0;
            cfg1_q       <= '0;
            exec_cfg_q   <= '0;
            running_q    <= 1'b0;
            tnum_q       <= '0;
            status_q     <= '0;
            rd_cnt_q     <= '0;
            read_q       <= '0;
            rd_valid_q   <= 1'b0;
            rst_req_q    <= 1'b0;
            exec_start_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            arr_sel_q    <= '0;
            wr_data_q    <= '0;
            rd_req_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cfg0_q       <= cfg0_d;
            cfg1_q       <= cfg1_d;
            exec_cfg_q   <= exec_cfg_d;
            running_q    <= running_d;
            tnum_q       <= tnum_d;
            status_q     <= status_d;
            rd_cnt_q     <= rd_cnt_d;
            read_q       <= read_d;
            rd_valid_q   <= rd_valid_d;
            rst_req_q    <= rst_req_d;
            exec_start_q <= exec_start_d;
            wr_valid_q   <= wr_valid_d;
            arr_sel_q    <= arr_sel_d;
            wr_data_q    <= wr_data_d;
            rd_req_q     <= rd_req_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cfg0_d       = cfg0_q;
        cfg1_d       = cfg1_q;
        exec_cfg_d   = exec_cfg_q;
        running_d    = running_q;
        tnum_d       = tnum_q;
        rd_cnt_d     = rd_cnt_q;
        read_d       = read_q;
        arr_sel_d    = arr_sel_q;
        wr_data_d    = wr_data_q;
        rd_req_d     = rd_req_q;
        rd_valid_d   = 1'b0;
        rst_req_d    = 1'b0;
        exec_start_d = 1'b0;
        wr_valid_d   = 1'b0;
        status_clr   = 1'b0;
        status_set   = '0;

        unique case (state_q)
            IDLE: begin
                if (sw_write32_valid && sw_write32[31:28] == FW_ID) begin
                    cmd_d   = sw_write32[27:0];
                    state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                state_d = IDLE;
                unique case (op)
                    NOOP: ;
                    W_RST_FW: begin
                        rst_req_d  = 1'b1;
                        cfg0_d     = '0;
                        cfg1_d     = '0;
                        exec_cfg_d = '0;
                        running_d  = 1'b0;
                        status_clr = 1'b1;
                        status_set[status_index_rst_fw] = 1'b1;
                    end
                    W_CFG_STATIC_0: begin
                        cfg0_d = body;
                        status_set[status_index_of(op)] = 1'b1;
                    end
                    W_CFG_STATIC_1: begin
                        cfg1_d = body;
                        status_set[status_index_of(op)] = 1'b1;
                    end
                    R_CFG_STATIC_0, R_CFG_STATIC_1: begin
                        read_d     = {FW_ID, op, (op == R_CFG_STATIC_0) ? cfg0_q : cfg1_q};
                        rd_valid_d = 1'b1;
                        status_set[status_index_of(op)] = 1'b1;
                    end
                    W_CFG_ARRAY_0, W_CFG_ARRAY_1, W_CFG_ARRAY_2: begin
                        wr_valid_d = 1'b1;
                        arr_sel_d  = arr_sel_of(op);
                        wr_data_d  = body;
                        status_set[status_index_of(op)] = 1'b1;
                    end
                    R_CFG_ARRAY_0, R_CFG_ARRAY_1, R_CFG_ARRAY_2,
                    R_DATA_ARRAY_0, R_DATA_ARRAY_1: begin
                        rd_req_d  = 1'b1;
                        arr_sel_d = arr_sel_of(op);
                        rd_cnt_d  = '0;
                        state_d   = RD_WAIT;
                    end
                    W_STATUS_FW_CLEAR: status_clr = 1'b1;
                    W_EXECUTE: begin
                        if (!$onehot(tnum) || running_q) begin
                            status_set[status_index_error_execute] = 1'b1;
                        end else begin
                            exec_cfg_d   = body;
                            exec_start_d = 1'b1;
                            running_d    = 1'b1;
                            tnum_d       = tnum;
                            status_set[status_index_of(op)] = 1'b1;
                        end
                    end
                endcase
            end
            RD_WAIT: begin
                if (arr_rd_ack) begin
                    rd_req_d   = 1'b0;
                    read_d     = {FW_ID, op, arr_rd_data};
                    rd_valid_d = 1'b1;
                    status_set[status_index_of(op)] = 1'b1;
                    state_d    = IDLE;
                end else if (rd_cnt_q == RD_LAST) begin
                    rd_req_d   = 1'b0;
                    read_d     = {FW_ID, op, 24'hFFFFFF};
                    rd_valid_d = 1'b1;
                    status_set[status_index_error_rd_timeout] = 1'b1;
                    state_d    = IDLE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sw_write32_valid && state_q != IDLE)
            status_set[status_index_error_cmd_dropped] = 1'b1;

        // Completion is tracked in every state and lands after any clear.
        if (running_q && |done_hit) begin
            running_d         = 1'b0;
            status_set[17:14] = done_hit;
        end

        status_d = (status_clr ? '0 : status_q) | status_set;
    end

    assign sw_read32       = read_q;
    assign sw_read32_valid = rd_valid_q;
    assign cmd_busy        = (state_q != IDLE);
    assign fw_rst_req      = rst_req_q;
    assign cfg_static_0    = cfg0_q;
    assign cfg_static_1    = cfg1_q;
    assign exec_cfg        = exec_cfg_q;
    assign exec_start      = exec_start_q;
    assign arr_wr_valid    = wr_valid_q;
    assign arr_sel         = arr_sel_q;
    assign arr_wr_data     = wr_data_q;
    assign arr_rd_req      = rd_req_q;
    assign status          = status_q;

endmodule
